mmio_timer64: RTL and testbench

- Memory-mapped 64-bit machine timer (mtime/mtimecmp style) in the system IO region.
- Free-running 64-bit counter plus 64-bit compare register, both accessed as four 32-bit words.
- Drives a level timer interrupt into the rv32apogeo core while counter >= compare.
- The system memory decoder supplies write strobe, word index and data; read data is muxed onto the load channel.

---
 rtl/mmio_timer64_if.sv | 20 ++
 rtl/mmio_timer64.sv | 86 ++++++++
 tb/tb_mmio_timer64.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer64_if.sv
// Decoder-side bus of the mmio_timer64 block: word-indexed write strobe and data,
// read word index, registered read data and the level timer interrupt.
interface mmio_timer64_if;
  logic        write_i;
  logic [31:0] write_data_i;
  logic [1:0]  write_address_i;
  logic [1:0]  read_address_i;
  logic [31:0] read_data_o;
  logic        timer_interrupt_o;

  modport master (
    output write_i, write_data_i, write_address_i, read_address_i,
    input  read_data_o, timer_interrupt_o
  );

  modport slave (
    input  write_i, write_data_i, write_address_i, read_address_i,
    output read_data_o, timer_interrupt_o
  );
endinterface

// File: rtl/mmio_timer64.sv
// 64-bit mtime/mtimecmp-style machine timer, exposed as four 32-bit words.
// Define MMIO_TIMER_PRESCALER_EN to divide the counter tick by PRESCALE.
module mmio_timer64 #(
  parameter logic [63:0] RESET_COMPARE = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESCALE      = 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  mmio_timer64_if.slave  bus
);
  logic [63:0] cnt_q, cnt_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        wr_cnt, wr_cmp, tick;

  // Word index bit 1 selects counter vs compare, bit 0 selects the half.
  assign wr_cnt = bus.write_i & ~bus.write_address_i[1];
  assign wr_cmp = bus.write_i &  bus.write_address_i[1];

`ifdef MMIO_TIMER_PRESCALER_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  logic [15:0] pre_q, pre_d;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? 16'd0 : pre_q + 16'd1;
    // Writing the counter restarts the tick period so the written value holds a full period.
    if (wr_cnt) pre_d = 16'd0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pre_q <= 16'd0;
    else          pre_q <= pre_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    cnt_d = cnt_q + {63'd0, tick};
    if (wr_cnt) begin
      if (bus.write_address_i[0]) cnt_d = {bus.write_data_i, cnt_q[31:0]};
      else                        cnt_d = {cnt_q[63:32], bus.write_data_i};
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp) begin
      if (bus.write_address_i[0]) cmp_d = {bus.write_data_i, cmp_q[31:0]};
      else                        cmp_d = {cmp_q[63:32], bus.write_data_i};
    end
  end

  // Reads see the pre-edge state, so a same-word write shows up on the next read.
  always_comb begin
    rdata_d = 32'd0;
    unique case (bus.read_address_i)
      2'd0: rdata_d = cnt_q[31:0];
      2'd1: rdata_d = cnt_q[63:32];
      2'd2: rdata_d = cmp_q[31:0];
      2'd3: rdata_d = cmp_q[63:32];
      default: rdata_d = 32'd0;
    endcase
  end

  assign irq_d = (cnt_d >= cmp_d);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= 64'd0;
      cmp_q   <= RESET_COMPARE;
      rdata_q <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.read_data_o       = rdata_q;
  assign bus.timer_interrupt_o = irq_q;
endmodule

// File: tb/tb_mmio_timer64.sv
// Randomized bench for mmio_timer64 against a word-level model of the timer.
module tb_mmio_timer64;
`ifdef MMIO_TIMER_PRESCALER_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif
  localparam logic [63:0] RC = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  mmio_timer64_if bus();

  mmio_timer64 #(.RESET_COMPARE(RC), .PRESCALE(P)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_cnt, m_cmp;
  logic [31:0] exp_rdata;
  logic        exp_irq;
  int          m_pre;

  function automatic logic [31:0] word_of(logic [1:0] a);
    case (a)
      2'd0: return m_cnt[31:0];
      2'd1: return m_cnt[63:32];
      2'd2: return m_cmp[31:0];
      default: return m_cmp[63:32];
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 64'd0; m_cmp = RC; exp_rdata = 32'd0; exp_irq = 1'b0; m_pre = 0;
  endtask

  // One clock edge: model consumes the inputs that were stable across the edge.
  task automatic step();
    logic [31:0] wd;
    @(posedge clk);
    if (rst_n) begin
      exp_rdata = word_of(bus.read_address_i);
      wd = bus.write_data_i;
      if (bus.write_i && bus.write_address_i == 2'd0) begin
        m_cnt[31:0] = wd; m_pre = 0;
      end else if (bus.write_i && bus.write_address_i == 2'd1) begin
        m_cnt[63:32] = wd; m_pre = 0;
      end else begin
        if (m_pre == P - 1) begin m_pre = 0; m_cnt = m_cnt + 64'd1; end
        else m_pre = m_pre + 1;
      end
      if (bus.write_i && bus.write_address_i == 2'd2) m_cmp[31:0]  = wd;
      if (bus.write_i && bus.write_address_i == 2'd3) m_cmp[63:32] = wd;
      exp_irq = (m_cnt >= m_cmp);
    end
    #1;
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    bus.write_i = 1'b1; bus.write_address_i = a; bus.write_data_i = d;
    step();
    bus.write_i = 1'b0;
  endtask

  // Continuous check of both outputs against the model, away from the active edge.
  always @(negedge clk) begin
    total++;
    if (bus.read_data_o !== exp_rdata) begin
      bad++;
      $display("FAIL cyc_rdata actual=%h expected=%h t=%0t", bus.read_data_o, exp_rdata, $time);
    end
    total++;
    if (bus.timer_interrupt_o !== exp_irq) begin
      bad++;
      $display("FAIL cyc_irq actual=%b expected=%b t=%0t", bus.timer_interrupt_o, exp_irq, $time);
    end
  end

  initial begin
    logic        found;
    logic [31:0] old;
    int          r;
    rst_n = 1'b0;
    bus.write_i = 1'b0; bus.write_data_i = 32'd0;
    bus.write_address_i = 2'd0; bus.read_address_i = 2'd0;
    model_reset();
    repeat (3) step();
    check("reset_rdata", {32'd0, bus.read_data_o}, 64'd0);
    check("reset_irq", {63'd0, bus.timer_interrupt_o}, 64'd0);
    rst_n = 1'b1;

    // Count-up after reset
`ifdef MMIO_TIMER_PRESCALER_EN
    repeat (40) step();
    check("presc40", {63'd0, (bus.read_data_o >= 32'd9 && bus.read_data_o <= 32'd11)}, 64'd1);
`else
    for (int i = 0; i < 4; i++) begin
      step();
      check("count_up", {32'd0, bus.read_data_o}, 64'(i));
    end
`endif
    bus.read_address_i = 2'd1; step();
    check("rd_cnt_hi", {32'd0, bus.read_data_o}, 64'd0);
    bus.read_address_i = 2'd2; step();
    check("rd_cmp_lo", {32'd0, bus.read_data_o}, 64'hFFFF_FFFF);
    bus.read_address_i = 2'd3; step();
    check("rd_cmp_hi", {32'd0, bus.read_data_o}, 64'hFFFF_FFFF);
    check("irq_idle", {63'd0, bus.timer_interrupt_o}, 64'd0);

    // Compare at 0x20: interrupt rises together with the counter reaching it
    bus.read_address_i = 2'd0;
    wr(2'd3, 32'd0);
    wr(2'd2, 32'h20);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (bus.timer_interrupt_o) found = 1'b1;
    end
    check("irq_rise_found", {63'd0, found}, 64'd1);
    check("irq_rise_cnt", m_cnt, 64'h20);
    check("irq_rise_rd", {32'd0, bus.read_data_o}, 64'h1F);
    repeat (5) step();
    check("irq_hold", {63'd0, bus.timer_interrupt_o}, 64'd1);

    // Compare moved above counter clears it
    wr(2'd3, 32'd1);
    check("irq_clear", {63'd0, bus.timer_interrupt_o}, 64'd0);

    // Wrap with compare 0: interrupt stays high
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd0);
    check("irq_cmp0", {63'd0, bus.timer_interrupt_o}, 64'd1);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    step();
    check("wrap_pre", {32'd0, bus.read_data_o}, 64'hFFFF_FFFF);
    bus.read_address_i = 2'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("wrap_irq", {63'd0, bus.timer_interrupt_o}, 64'd1);
    end
    check("wrap_hi", {32'd0, bus.read_data_o}, 64'd0);

    // Same-word write and read
    bus.read_address_i = 2'd0;
    old = m_cnt[31:0];
    wr(2'd0, 32'h100);
    check("rw_old", {32'd0, bus.read_data_o}, {32'd0, old});
    step();
    check("rw_new", {32'd0, bus.read_data_o}, 64'h100);
    repeat (P) step();
    check("rw_next", {32'd0, bus.read_data_o}, 64'h101);

    // Random traffic, biased so compare lands near the counter
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      bus.read_address_i  = 2'($urandom_range(0, 3));
      bus.write_i         = (r < 4);
      bus.write_address_i = 2'($urandom_range(0, 3));
      case (bus.write_address_i)
        2'd0: bus.write_data_i = (r == 0) ? $urandom : m_cnt[31:0] - 32'($urandom_range(0, 30));
        2'd1: bus.write_data_i = (r == 0) ? $urandom : m_cnt[63:32] + 32'($urandom_range(0, 1));
        2'd2: bus.write_data_i = m_cnt[31:0] + 32'($urandom_range(0, 40)) - 32'd20;
        default: bus.write_data_i = m_cnt[63:32] + 32'($urandom_range(0, 1)) - 32'((r == 3) ? 1 : 0);
      endcase
      step();
    end
    bus.write_i = 1'b0;

    // Asynchronous reset mid-run
    wr(2'd2, 32'd0);
    wr(2'd3, 32'd0);
    bus.read_address_i = 2'd3;
    wr(2'd1, 32'h55);
    bus.read_address_i = 2'd1;
    step();
    check("pre_rst_rd", {32'd0, bus.read_data_o}, 64'h55);
    check("pre_rst_irq", {63'd0, bus.timer_interrupt_o}, 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_rd", {32'd0, bus.read_data_o}, 64'd0);
    check("async_rst_irq", {63'd0, bus.timer_interrupt_o}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    bus.read_address_i = 2'd0;
    step();
    check("post_rst_rd", {32'd0, bus.read_data_o}, 64'd0);
    bus.read_address_i = 2'd2;
    step();
    check("post_rst_cmp", {32'd0, bus.read_data_o}, 64'hFFFF_FFFF);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
